// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and helpers for the SHA-256 block sequencer
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned DIGEST_WORDS    = 8;

  // Blocks needed for a message of `size` bytes: data, 0x80 marker, 64-bit length.
  function automatic logic [31:0] calc_nblk(input logic [31:0] size,
                                            input logic [31:0] max_blocks);
    logic [32:0] n;
    n = (({1'b0, size} + 33'd8) >> 6) + 33'd1;
    if (n > {1'b0, max_blocks}) begin
      n = {1'b0, max_blocks};
    end
    return n[31:0];
  endfunction

  // Keep the bytes before byte_idx (MSB-first), put 0x80 at byte_idx, zero the rest.
  function automatic logic [31:0] pad_word(input logic [31:0] word,
                                           input logic [1:0]  byte_idx);
    logic [31:0] keep;
    case (byte_idx)
      2'd0:    keep = 32'h0000_0000;
      2'd1:    keep = 32'hFF00_0000;
      2'd2:    keep = 32'hFFFF_0000;
      default: keep = 32'hFFFF_FF00;
    endcase
    return (word & keep) | (32'h8000_0000 >> {byte_idx, 3'b000});
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// rtl/sha256_pad_word.sv - inserts the 0x80 end-of-message marker into one word
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_idx,
  input  logic        is_pad_word,
  output logic [31:0] padded
);

  // Words other than the marker word pass through untouched.
  always_comb begin
    padded = is_pad_word ? pad_word(word, byte_idx) : word;
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - fetches, pads and issues SHA-256 blocks, writes back the digest
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MAX_BLOCKS = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       size,
  input  logic [31:0]       output_addr,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_first,
  output logic [511:0]      blk_words,
  input  logic              core_done,
  input  logic [255:0]      digest
);

  localparam int unsigned BLK_W = $clog2(MAX_BLOCKS + 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] msg_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic [31:0]       size_q;
  logic [BLK_W-1:0]  nblk_q;
  logic [BLK_W-1:0]  blk_q;
  logic [4:0]        rd_idx_q;
  logic              rd_pend_q;
  logic [3:0]        rd_pend_idx_q;
  logic [2:0]        wr_idx_q;
  logic [31:0]       buf_q [WORDS_PER_BLOCK];
  logic [255:0]      digest_q;

  logic [31:0]       blk_base;
  logic [31:0]       rem;
  logic [4:0]        rd_cnt;
  logic              pad_here;
  logic              is_last_blk;
  logic              issue_rd;
  logic              enter_read;
  logic [31:0]       pad_out;

  assign mem_clk = clk;

  // Per-block geometry: bytes remaining, words to fetch, where the marker lands.
  always_comb begin
    logic [31:0] rnd;
    blk_base = '0;
    blk_base[BLK_W+5:6] = blk_q;
    rem = (size_q > blk_base) ? (size_q - blk_base) : 32'd0;
    rnd = rem + 32'd3;
    rd_cnt = (rem >= 32'd64) ? 5'd16 : rnd[6:2];
    pad_here = (size_q >= blk_base) && (rem < 32'd64);
    is_last_blk = (blk_q == nblk_q - BLK_W'(1));
    issue_rd = (state == ST_READ) && (rd_idx_q < rd_cnt);
  end

  sha256_pad_word u_pad_word (
    .word        (buf_q[rem[5:2]]),
    .byte_idx    (rem[1:0]),
    .is_pad_word (pad_here),
    .padded      (pad_out)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx   = state;
    enter_read = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx   = ST_READ;
          enter_read = 1'b1;
        end
      end
      ST_READ: begin
        if (!issue_rd) begin
          state_nx = ST_PAD;
        end
      end
      ST_PAD: begin
        state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (blk_ready) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          if (is_last_blk) begin
            state_nx = ST_WRITE;
          end else begin
            state_nx   = ST_READ;
            enter_read = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (wr_idx_q == 3'd7) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; memory is idle (address 0) whenever not reading or writing.
  always_comb begin
    done           = (state == ST_DONE);
    blk_valid      = (state == ST_ISSUE);
    blk_first      = (state == ST_ISSUE) && (blk_q == '0);
    mem_we         = (state == ST_WRITE);
    mem_addr       = '0;
    mem_write_data = '0;
    if (state == ST_WRITE) begin
      mem_addr       = out_base_q + ADDR_W'(wr_idx_q);
      mem_write_data = digest_q[{~wr_idx_q, 5'b00000} +: 32];
    end else if (issue_rd) begin
      mem_addr = msg_base_q + (ADDR_W'(blk_q) << 4) + ADDR_W'(rd_idx_q);
    end
  end

  // Present the buffer MSB-first: W[0] in the top word.
  always_comb begin
    blk_words = '0;
    for (int i = 0; i < 16; i++) begin
      blk_words[511-32*i -: 32] = buf_q[i];
    end
  end

  // Job registers, read pipeline, padding and digest capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_base_q    <= '0;
      out_base_q    <= '0;
      size_q        <= '0;
      nblk_q        <= '0;
      blk_q         <= '0;
      rd_idx_q      <= '0;
      rd_pend_q     <= 1'b0;
      rd_pend_idx_q <= '0;
      wr_idx_q      <= '0;
      digest_q      <= '0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      if (state == ST_IDLE && start) begin
        msg_base_q <= message_addr[ADDR_W-1:0];
        out_base_q <= output_addr[ADDR_W-1:0];
        size_q     <= size;
        nblk_q     <= BLK_W'(calc_nblk(size, 32'(MAX_BLOCKS)));
        blk_q      <= '0;
      end

      if (state == ST_WAIT && core_done) begin
        if (is_last_blk) begin
          digest_q <= digest;
          wr_idx_q <= '0;
        end else begin
          blk_q <= blk_q + BLK_W'(1);
        end
      end

      // A fresh block starts from an all-zero buffer so unread words read as 0.
      if (enter_read) begin
        rd_idx_q  <= '0;
        rd_pend_q <= 1'b0;
        for (int i = 0; i < 16; i++) begin
          buf_q[i] <= '0;
        end
      end else if (state == ST_READ) begin
        rd_pend_q     <= issue_rd;
        rd_pend_idx_q <= rd_idx_q[3:0];
        if (issue_rd) begin
          rd_idx_q <= rd_idx_q + 5'd1;
        end
        if (rd_pend_q) begin
          buf_q[rd_pend_idx_q] <= mem_read_data;
        end
      end

      // Length field is written after the marker so it wins on the last block.
      if (state == ST_PAD) begin
        if (pad_here) begin
          buf_q[rem[5:2]] <= pad_out;
        end
        if (is_last_blk) begin
          buf_q[14] <= {29'd0, size_q[31:29]};
          buf_q[15] <= {size_q[28:0], 3'b000};
        end
      end

      if (state == ST_WRITE) begin
        wr_idx_q <= wr_idx_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb/tb_sha256_block_sequencer.sv - scoreboard bench for the SHA-256 block sequencer
module tb_sha256_block_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  message_addr = '0;
  logic [31:0]  size = '0;
  logic [31:0]  output_addr = '0;
  logic         done;
  logic         mem_clk;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [31:0]  mem_read_data;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic         blk_first;
  logic [511:0] blk_words;
  logic         core_done = 1'b0;
  logic [255:0] digest = '0;

  always #5 clk = ~clk;

  sha256_block_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .message_addr   (message_addr),
    .size           (size),
    .output_addr    (output_addr),
    .done           (done),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blk_first      (blk_first),
    .blk_words      (blk_words),
    .core_done      (core_done),
    .digest         (digest)
  );

  typedef struct packed {
    logic         first;
    logic [511:0] words;
  } blk_exp_t;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [31:0]  mem [0:1023];
  blk_exp_t     exp_blk [$];
  logic [15:0]  exp_wr_addr [$];
  logic [31:0]  exp_wr_data [$];
  int           exp_done = 0;
  int           rd_count = 0;
  int           wr_seen = 0;
  logic [15:0]  cur_msg = '0;
  logic [255:0] job_digest = '0;
  logic [31:0]  w [16];

  always @(posedge clk) mem_read_data <= mem[mem_addr[9:0]];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_w();
    for (int i = 0; i < 16; i++) w[i] = 32'd0;
  endtask

  task automatic push_blk(input logic first);
    blk_exp_t e;
    e.first = first;
    for (int i = 0; i < 16; i++) e.words[511-32*i -: 32] = w[i];
    exp_blk.push_back(e);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_write_data, 0);
    check({tag, "_blk_valid"}, blk_valid, 0);
    check({tag, "_blk_first"}, blk_first, 0);
    check({tag, "_blk_words"}, blk_words, 0);
  endtask

  // Monitor: compares handshaken blocks, memory writes and done pulses against the queues.
  initial begin : monitor
    blk_exp_t e;
    forever begin
      @(negedge clk);
      if (blk_valid && blk_ready) begin
        check("block_expected", exp_blk.size() != 0, 1);
        if (exp_blk.size() != 0) begin
          e = exp_blk.pop_front();
          check("blk_words", blk_words, e.words);
          check("blk_first", blk_first, e.first);
        end
      end
      if (mem_we) begin
        wr_seen++;
        check("write_expected", exp_wr_addr.size() != 0, 1);
        if (exp_wr_addr.size() != 0) begin
          check("wr_addr", mem_addr, exp_wr_addr.pop_front());
          check("wr_data", mem_write_data, exp_wr_data.pop_front());
        end
      end else if (mem_addr >= cur_msg && mem_addr < cur_msg + 16'd64) begin
        rd_count++;
      end
      if (done) begin
        check("done_expected", exp_done != 0, 1);
        check("writes_before_done", exp_wr_addr.size(), 0);
        if (exp_done != 0) exp_done--;
      end
    end
  end

  // Stub compression core: finishes each accepted block three cycles later.
  initial begin : core_stub
    forever begin
      @(negedge clk);
      if (blk_valid && blk_ready) begin
        repeat (3) @(posedge clk);
        #1;
        digest = job_digest;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  task automatic run_job(input logic [31:0] sz, input logic [31:0] msg, input logic [31:0] out,
                         input int exp_lat, input int exp_reads, input bit hold, input bit poke);
    int lat;
    int cyc;
    logic [511:0] snap;
    cur_msg = msg[15:0];
    rd_count = 0;
    for (int i = 0; i < 8; i++) begin
      job_digest[255-32*i -: 32] = 32'hD1E5_0000 + (sz << 4) + 32'(i);
      exp_wr_addr.push_back(out[15:0] + 16'(i));
      exp_wr_data.push_back(32'hD1E5_0000 + (sz << 4) + 32'(i));
    end
    exp_done++;
    if (hold) blk_ready = 1'b0;
    @(posedge clk); #1;
    message_addr = msg;
    size = sz;
    output_addr = out;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!blk_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (hold) begin
      snap = blk_words;
      repeat (10) begin
        @(posedge clk); #1;
        check("hold_valid", blk_valid, 1);
        check("hold_words", blk_words, snap);
      end
      blk_ready = 1'b1;
    end
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (exp_done != 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("job_finished", exp_done, 0);
    check("reads_issued", rd_count, exp_reads);
    check("blocks_consumed", exp_blk.size(), 0);
    check("writes_done", exp_wr_addr.size(), 0);
  endtask

  initial begin : stimulus
    int lat;
    int wr_before;
    for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
    for (int k = 0; k < 16; k++) mem[16'h40 + k] = 32'hA0B0_C000 + 32'(k);
    mem[16'h200] = 32'h6162_6380;

    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    reset_n = 1'b1;

    // size=0: marker alone; digest written across the address wrap.
    clear_w();
    w[0] = 32'h8000_0000;
    push_blk(1'b1);
    run_job(32'd0, 32'h40, 32'h0001_FFFC, 2, 0, 1'b0, 1'b0);

    // size=3: "abc".
    clear_w();
    w[0] = 32'h6162_6380;
    w[15] = 32'h18;
    push_blk(1'b1);
    run_job(32'd3, 32'h200, 32'h300, 3, 1, 1'b0, 1'b0);

    // size=55: marker in byte 3 of W13; core holds off for 10 cycles.
    clear_w();
    for (int k = 0; k < 13; k++) w[k] = 32'hA0B0_C000 + 32'(k);
    w[13] = 32'hA0B0_C080;
    w[15] = 32'h1B8;
    push_blk(1'b1);
    run_job(32'd55, 32'h40, 32'h300, 16, 14, 1'b1, 1'b0);

    // size=56: marker in W14, length spills to a second block; stray start ignored.
    clear_w();
    for (int k = 0; k < 14; k++) w[k] = 32'hA0B0_C000 + 32'(k);
    w[14] = 32'h8000_0000;
    push_blk(1'b1);
    clear_w();
    w[15] = 32'h1C0;
    push_blk(1'b0);
    run_job(32'd56, 32'h40, 32'h300, 16, 14, 1'b0, 1'b1);

    // size=64: full data block, marker in W0 of block 1 with no further reads.
    clear_w();
    for (int k = 0; k < 16; k++) w[k] = 32'hA0B0_C000 + 32'(k);
    push_blk(1'b1);
    clear_w();
    w[0] = 32'h8000_0000;
    w[15] = 32'h200;
    push_blk(1'b0);
    run_job(32'd64, 32'h40, 32'h300, 18, 16, 1'b0, 1'b0);

    // Reset while waiting on the core: job abandoned, no digest write.
    clear_w();
    w[0] = 32'h8000_0000;
    push_blk(1'b1);
    cur_msg = 16'h40;
    @(posedge clk); #1;
    message_addr = 32'h40;
    size = 32'd0;
    output_addr = 32'h300;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!blk_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rst_latency", lat, 2);
    @(posedge clk); #2;
    wr_before = wr_seen;
    reset_n = 1'b0;
    #1;
    check_quiet_outputs("midwait_reset");
    check("rst_block_consumed", exp_blk.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_quiet_outputs("after_reset");
    check("rst_no_write", wr_seen - wr_before, 0);
    check("rst_no_done", exp_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
